// File: rtl/led_pwm_pkg.sv
// Shared constants and helpers for the LED PWM driver (channel layout, duty type).
// Optional duty fading is enabled by defining LED_PWM_FADE_EN.
package led_pwm_pkg;

  localparam int NUM_PIX   = 4;
  localparam int NUM_CH    = 12;
  localparam int COL_R     = 0;
  localparam int COL_G     = 4;
  localparam int COL_B     = 8;
  localparam int DUTY_BITS = 8;

  typedef logic [DUTY_BITS-1:0] duty_t;

  // Blue is lit only where both red and green of the pixel are lit.
  function automatic logic ch_on(input logic r, input logic g, input int col);
    logic on_s;
    if (col == COL_R) begin
      on_s = r;
    end else if (col == COL_G) begin
      on_s = g;
    end else if (col == COL_B) begin
      on_s = r & g;
    end else begin
      on_s = 1'b0;
    end
    return on_s;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: duty register (optional fade stepper under LED_PWM_FADE_EN)
// and registered PWM comparator.
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] pwm_ctr,
  input  logic         period_tick,
  input  logic         fade_tick,
  input  logic [W-1:0] target,
  output logic         led
);

`ifdef LED_PWM_FADE_EN
  localparam bit FADE_EN = 1'b1;
`else
  localparam bit FADE_EN = 1'b0;
`endif

  localparam logic [W-1:0] DUTY_FULL = {W{1'b1}};

  logic [W-1:0] duty_r;
  logic [W-1:0] duty_nxt_s;
  logic         led_r;

  // Next duty: only ever changes at the period boundary.
  always_comb begin
    duty_nxt_s = duty_r;
    if (period_tick) begin
      if (FADE_EN) begin
        if (fade_tick) begin
          if (duty_r < target) begin
            duty_nxt_s = duty_r + W'(1);
          end else if (duty_r > target) begin
            duty_nxt_s = duty_r - W'(1);
          end else begin
            duty_nxt_s = duty_r;
          end
        end else begin
          duty_nxt_s = duty_r;
        end
      end else begin
        duty_nxt_s = target;
      end
    end else begin
      duty_nxt_s = duty_r;
    end
  end

  // Duty and output registers; a full-scale duty is held solidly on.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_r <= {W{1'b0}};
      led_r  <= 1'b0;
    end else begin
      duty_r <= duty_nxt_s;
      led_r  <= (duty_r == DUTY_FULL) ? 1'b1 : (duty_r > pwm_ctr);
    end
  end

  assign led = led_r;

endmodule

// File: rtl/led_pwm_driver.sv
// Drives 12 board LEDs (R, G, B=R&G per pixel) from the SoC LED word with PWM brightness.
// Define LED_PWM_FADE_EN to ramp each duty toward its target instead of switching instantly.
module led_pwm_driver
  import led_pwm_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE     = 64,
  parameter int FADE_PERIODS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          led_in,
  input  logic [PWM_BITS-1:0] bright,
  output logic [11:0]         led_out,
  output logic                period_tick
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [7:0]          led_q_r;
  logic [PRE_W-1:0]    pre_ctr_r;
  logic [PWM_BITS-1:0] pwm_ctr_r;
  logic                period_tick_r;
  logic                step_s;
  logic                wrap_s;
  logic                fade_tick_s;

  assign step_s = (pre_ctr_r == PRE_W'(PRESCALE - 1));
  assign wrap_s = step_s && (pwm_ctr_r == {PWM_BITS{1'b1}});

  // Input capture, prescaler and PWM counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q_r       <= 8'h00;
      pre_ctr_r     <= {PRE_W{1'b0}};
      pwm_ctr_r     <= {PWM_BITS{1'b0}};
      period_tick_r <= 1'b0;
    end else begin
      led_q_r       <= led_in;
      period_tick_r <= wrap_s;
      if (step_s) begin
        pre_ctr_r <= {PRE_W{1'b0}};
        pwm_ctr_r <= pwm_ctr_r + PWM_BITS'(1);
      end else begin
        pre_ctr_r <= pre_ctr_r + PRE_W'(1);
        pwm_ctr_r <= pwm_ctr_r;
      end
    end
  end

`ifdef LED_PWM_FADE_EN
  localparam int FADE_W = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;

  logic [FADE_W-1:0] fade_ctr_r;

  assign fade_tick_s = wrap_s && (fade_ctr_r == FADE_W'(FADE_PERIODS - 1));

  // Counts PWM periods between fade steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      fade_ctr_r <= {FADE_W{1'b0}};
    end else if (fade_tick_s) begin
      fade_ctr_r <= {FADE_W{1'b0}};
    end else if (wrap_s) begin
      fade_ctr_r <= fade_ctr_r + FADE_W'(1);
    end else begin
      fade_ctr_r <= fade_ctr_r;
    end
  end
`else
  assign fade_tick_s = 1'b0;
`endif

  // Channels update duty on the wrap edge itself, so the new duty starts exactly at pwm_ctr=0.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam int PIX = g % NUM_PIX;
    localparam int COL = g - PIX;

    logic [PWM_BITS-1:0] target_s;

    assign target_s = ch_on(led_q_r[2*PIX], led_q_r[2*PIX+1], COL) ? bright
                                                                   : {PWM_BITS{1'b0}};

    led_pwm_channel #(.W(PWM_BITS)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .pwm_ctr     (pwm_ctr_r),
      .period_tick (wrap_s),
      .fade_tick   (fade_tick_s),
      .target      (target_s),
      .led         (led_out[g])
    );
  end

  assign period_tick = period_tick_r;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver (PRESCALE=1, PWM_BITS=8, FADE_PERIODS=2);
// runs the fade scenarios when LED_PWM_FADE_EN is defined, the instant-load ones otherwise.
module tb_led_pwm_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  led_in;
  logic [7:0]  bright;
  logic [11:0] led_out;
  logic        period_tick;

  int n_vec  = 0;
  int n_miss = 0;
  int cnt [12];
  int tick_cnt;

  logic [7:0] m_duty;
  logic [7:0] m_led;
  logic [7:0] m_br;
  int         m_wraps;

  always #5 clk = ~clk;

  led_pwm_driver #(
    .PWM_BITS     (8),
    .PRESCALE     (1),
    .FADE_PERIODS (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .led_in      (led_in),
    .bright      (bright),
    .led_out     (led_out),
    .period_tick (period_tick)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // High cycles expected in one period for channel ch.
  function automatic int exp_cnt(input logic [7:0] led, input logic [7:0] br, input int ch);
    int  pix;
    int  col;
    logic on;
    pix = ch % 4;
    col = ch / 4;
    on  = (col == 0) ? led[2*pix] : (col == 1) ? led[2*pix+1] : (led[2*pix] & led[2*pix+1]);
    if (!on) return 0;
    return (br == 8'd255) ? 256 : int'(br);
  endfunction

  task automatic wait_tick(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (period_tick) seen = 1'b1;
    end
    if (!seen) chk(tag, 0, 1);
  endtask

  // Counts high cycles per channel over the period that follows a period_tick.
  task automatic measure(input int chg_at, input logic [7:0] chg_br);
    for (int ch = 0; ch < 12; ch++) cnt[ch] = 0;
    tick_cnt = 0;
    for (int k = 1; k <= 256; k++) begin
      @(posedge clk);
      #1;
      for (int ch = 0; ch < 12; ch++) cnt[ch] += int'(led_out[ch]);
      if (period_tick) tick_cnt++;
      if (k == chg_at) bright = chg_br;
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] led, input logic [7:0] br);
    for (int ch = 0; ch < 12; ch++)
      chk($sformatf("%s_ch%0d", tag, ch), cnt[ch], exp_cnt(led, br, ch));
    chk({tag, "_ticks"}, tick_cnt, 1);
  endtask

  task automatic wrap_model();
    logic [7:0] tgt;
    m_wraps++;
    tgt = m_led[2] ? m_br : 8'd0;
    if (m_wraps % 2 == 0) begin
      if (m_duty < tgt) m_duty = m_duty + 8'd1;
      else if (m_duty > tgt) m_duty = m_duty - 8'd1;
    end
  endtask

  task automatic fade_period(input string tag);
    int others;
    measure(-1, 8'd0);
    others = 0;
    for (int ch = 0; ch < 12; ch++) if (ch != 1) others += cnt[ch];
    chk(tag, cnt[1], int'(m_duty));
    chk({tag, "_others"}, others, 0);
    wrap_model();
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    led_in = 8'hFF;
    bright = 8'd255;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("rst_led", int'(led_out), 0);
      chk("rst_tick", int'(period_tick), 0);
    end
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (period_tick) break;
    end
    chk("first_tick", n, 256);
    chk("first_tick_led", int'(led_out), 0);

`ifndef LED_PWM_FADE_EN
    led_in = 8'h01; bright = 8'd64;
    wait_tick("t2_wait");
    measure(-1, 8'd0); check_all("t2a", 8'h01, 8'd64);
    measure(-1, 8'd0); check_all("t2b", 8'h01, 8'd64);

    led_in = 8'h03; bright = 8'd255;
    wait_tick("t3a_wait");
    measure(-1, 8'd0); check_all("t3a", 8'h03, 8'd255);
    led_in = 8'h02;
    wait_tick("t3b_wait");
    measure(-1, 8'd0); check_all("t3b", 8'h02, 8'd255);

    led_in = 8'h01; bright = 8'd200;
    wait_tick("t4_wait");
    measure(100, 8'd10); check_all("t4a", 8'h01, 8'd200);
    measure(-1, 8'd0);   check_all("t4b", 8'h01, 8'd10);
`else
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    led_in = 8'h04; bright = 8'd8; reset = 1'b0;
    m_led = 8'h04; m_br = 8'd8; m_duty = 8'd0; m_wraps = 0;
    wait_tick("fade_wait");
    wrap_model();
    for (int p = 0; p < 18; p++) fade_period($sformatf("up_p%0d", p));
    led_in = 8'h00; m_led = 8'h00;
    for (int p = 0; p < 18; p++) fade_period($sformatf("down_p%0d", p));
    led_in = 8'h04; m_led = 8'h04;
    for (int p = 0; p < 40 && m_duty != 8'd5; p++) fade_period($sformatf("up2_p%0d", p));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_led", int'(led_out), 0);
    chk("midrst_tick", int'(period_tick), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_duty = 8'd0; m_wraps = 0;
    wait_tick("rst_ramp_wait");
    wrap_model();
    for (int p = 0; p < 6; p++) fade_period($sformatf("rst_ramp_p%0d", p));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
